// File: rtl/comparator_pkg.sv
// Shared types and constants for the pipelined magnitude comparator.
// Flag ordering in cmp_flags_t matches the {greater, equal, lesser} output bundle.
package comparator_pkg;

  typedef struct packed {
    logic greater;
    logic equal;
    logic lesser;
  } cmp_flags_t;

  typedef enum logic {
    CMP_UNSIGNED = 1'b0,
    CMP_SIGNED   = 1'b1
  } cmp_mode_e;

  // Seed fed into the least significant chunk: nothing resolved yet, operands equal so far.
  localparam cmp_flags_t CMP_FLAGS_EQ   = '{greater: 1'b0, equal: 1'b1, lesser: 1'b0};
  localparam cmp_flags_t CMP_FLAGS_NONE = '{greater: 1'b0, equal: 1'b0, lesser: 1'b0};
  localparam cmp_flags_t CMP_FLAGS_GT   = '{greater: 1'b1, equal: 1'b0, lesser: 1'b0};
  localparam cmp_flags_t CMP_FLAGS_LT   = '{greater: 1'b0, equal: 1'b0, lesser: 1'b1};

endpackage

// File: rtl/comparator_chunk.sv
// Combinational resolver for one STAGE_BITS-wide slice of the operands.
// Bits ripple LSB to MSB, so the most significant differing bit decides the result.
module comparator_chunk
  import comparator_pkg::*;
#(
  parameter int STAGE_BITS = 8
) (
  input  logic [STAGE_BITS-1:0] a_i,
  input  logic [STAGE_BITS-1:0] b_i,
  input  logic                  msb_signed_i,
  input  cmp_flags_t            flags_i,
  output cmp_flags_t            flags_o
);

  always_comb begin
    flags_o = flags_i;
    for (int i = 0; i < STAGE_BITS; i++) begin
      if (a_i[i] != b_i[i]) begin
        // A set sign bit makes the operand smaller, so the top bit compares with a/b swapped.
        if ((msb_signed_i && (i == STAGE_BITS - 1)) ? b_i[i] : a_i[i]) begin
          flags_o = CMP_FLAGS_GT;
        end else begin
          flags_o = CMP_FLAGS_LT;
        end
      end
    end
  end

endmodule

// File: rtl/comparator_nbit_pipelined.sv
// Pipelined WIDTH-bit comparator resolving STAGE_BITS per stage, least significant slice first,
// with valid/ready handshakes on both sides and a single global stage enable.
module comparator_nbit_pipelined
  import comparator_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int STAGE_BITS = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             signed_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic             greater_o,
  output logic             equal_o,
  output logic             lesser_o
);

  localparam int STAGES = WIDTH / STAGE_BITS;
  // Stage k keeps only the (STAGES-1-k)*STAGE_BITS operand bits still unresolved;
  // all of them are packed back to back into one vector per operand.
  localparam int UP_BITS = STAGE_BITS * STAGES * (STAGES - 1) / 2;
  localparam int UP_W    = (UP_BITS > 0) ? UP_BITS : 1;
  localparam int SGN_W   = (STAGES > 1) ? STAGES - 1 : 1;

  if ((WIDTH % STAGE_BITS) != 0 || WIDTH < 8 || WIDTH > 64) begin : g_param_check
    $error("comparator_nbit_pipelined: WIDTH must be 8..64 and a multiple of STAGE_BITS");
  end

  // Handshake: an input transfers when valid_i & ready_o, a result when valid_o & ready_i.
  // Every stage advances together when en=1 and holds (valid bits included) when en=0.
  logic       en;
  logic       vld_q   [STAGES];
  cmp_flags_t flags_q [STAGES];
  logic [UP_W-1:0]  up_a_q;
  logic [UP_W-1:0]  up_b_q;
  logic [SGN_W-1:0] sgn_q;
  cmp_mode_e        mode_in;

  assign valid_o = vld_q[STAGES-1];
  assign en      = ~valid_o | ready_i;
  assign ready_o = en;
  assign mode_in = cmp_mode_e'(signed_i);

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int IN_W    = WIDTH - k * STAGE_BITS;
    localparam int REM     = IN_W - STAGE_BITS;
    localparam int OFF_IN  = STAGE_BITS * ((k - 1) * (STAGES - 1) - ((k - 1) * (k - 2)) / 2);
    localparam int OFF_OUT = STAGE_BITS * (k * (STAGES - 1) - (k * (k - 1)) / 2);

    logic [IN_W-1:0] a_in;
    logic [IN_W-1:0] b_in;
    cmp_flags_t      f_in;
    cmp_flags_t      f_out;
    logic            sgn_in;
    logic            vld_in;
    logic            msb_sgn;

    if (k == 0) begin : g_head
      assign a_in   = a_i;
      assign b_in   = b_i;
      assign f_in   = CMP_FLAGS_EQ;
      assign sgn_in = (mode_in == CMP_SIGNED);
      assign vld_in = valid_i & ready_o;
    end else begin : g_body
      assign a_in   = up_a_q[OFF_IN +: IN_W];
      assign b_in   = up_b_q[OFF_IN +: IN_W];
      assign f_in   = flags_q[k-1];
      assign sgn_in = sgn_q[k-1];
      assign vld_in = vld_q[k-1];
    end

    // Only the slice holding operand bit WIDTH-1 may see the signed swap.
    if (k == STAGES - 1) begin : g_msb
      assign msb_sgn = sgn_in;
    end else begin : g_lsb
      assign msb_sgn = 1'b0;
    end

    comparator_chunk #(
      .STAGE_BITS(STAGE_BITS)
    ) u_chunk (
      .a_i         (a_in[STAGE_BITS-1:0]),
      .b_i         (b_in[STAGE_BITS-1:0]),
      .msb_signed_i(msb_sgn),
      .flags_i     (f_in),
      .flags_o     (f_out)
    );

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        vld_q[k]   <= 1'b0;
        flags_q[k] <= CMP_FLAGS_NONE;
      end else if (en) begin
        vld_q[k]   <= vld_in;
        flags_q[k] <= f_out;
      end
    end

    if (k < STAGES - 1) begin : g_fwd
      always_ff @(posedge clk_i) begin
        if (en) begin
          up_a_q[OFF_OUT +: REM] <= a_in[IN_W-1:STAGE_BITS];
          up_b_q[OFF_OUT +: REM] <= b_in[IN_W-1:STAGE_BITS];
          sgn_q[k]               <= sgn_in;
        end
      end
    end
  end

  // Bubbles carry stale partial flags, so the outputs are masked while no result is valid.
  assign {greater_o, equal_o, lesser_o} = valid_o ? flags_q[STAGES-1] : CMP_FLAGS_NONE;

endmodule

// File: tb/tb_comparator_nbit_pipelined.sv
// Bench for comparator_nbit_pipelined: a 32/8 instance for the handshake scenarios and
// a 64/16 instance for the wide signed case, checked against an arithmetic reference.
module tb_comparator_nbit_pipelined;
  import comparator_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_i = 1'b1;
  logic        valid_i = 1'b0, ready_i = 1'b0, signed_i = 1'b0;
  logic [31:0] a_i = '0, b_i = '0;
  logic        ready_o, valid_o, greater_o, equal_o, lesser_o;

  logic        w_valid_i = 1'b0, w_ready_i = 1'b1, w_signed_i = 1'b0;
  logic [63:0] w_a_i = '0, w_b_i = '0;
  logic        w_ready_o, w_valid_o, w_greater_o, w_equal_o, w_lesser_o;

  comparator_nbit_pipelined #(.WIDTH(32), .STAGE_BITS(8)) dut (
    .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
    .a_i(a_i), .b_i(b_i), .signed_i(signed_i), .valid_o(valid_o), .ready_i(ready_i),
    .greater_o(greater_o), .equal_o(equal_o), .lesser_o(lesser_o)
  );

  comparator_nbit_pipelined #(.WIDTH(64), .STAGE_BITS(16)) dut64 (
    .clk_i(clk), .rst_i(rst_i), .valid_i(w_valid_i), .ready_o(w_ready_o),
    .a_i(w_a_i), .b_i(w_b_i), .signed_i(w_signed_i), .valid_o(w_valid_o), .ready_i(w_ready_i),
    .greater_o(w_greater_o), .equal_o(w_equal_o), .lesser_o(w_lesser_o)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;
  logic [2:0] exp_q[$];

  function automatic logic [2:0] model32(input logic [31:0] x, input logic [31:0] y, input logic s);
    logic gt, lt;
    gt = s ? ($signed(x) > $signed(y)) : (x > y);
    lt = s ? ($signed(x) < $signed(y)) : (x < y);
    return {gt, x == y, lt};
  endfunction

  function automatic logic [2:0] model64(input logic [63:0] x, input logic [63:0] y, input logic s);
    logic gt, lt;
    gt = s ? ($signed(x) > $signed(y)) : (x > y);
    lt = s ? ($signed(x) < $signed(y)) : (x < y);
    return {gt, x == y, lt};
  endfunction

  function automatic logic [31:0] pick_b(input logic [31:0] x);
    case ($urandom_range(0, 3))
      0:       return x;
      1:       return $urandom;
      default: return x ^ (32'h1 << $urandom_range(0, 31));
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    tick();
    tick();
    n_cmp++;
    if (valid_o !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %b expected 0", valid_o); end
    n_cmp++;
    if ({greater_o, equal_o, lesser_o} !== 3'b000) begin
      n_bad++; $display("FAIL rst_flags: got %b expected 000", {greater_o, equal_o, lesser_o});
    end
    rst_i = 1'b0;
    tick();
    #1;
    n_cmp++;
    if (ready_o !== 1'b1) begin n_bad++; $display("FAIL rst_ready: got %b expected 1", ready_o); end
    n_cmp++;
    if (w_ready_o !== 1'b1 || w_valid_o !== 1'b0) begin
      n_bad++; $display("FAIL rst_wide: got ready=%b valid=%b expected 1 0", w_ready_o, w_valid_o);
    end
  endtask

  task automatic test_directed();
    logic [31:0] ta[6];
    logic [31:0] tb[6];
    logic        ts[6];
    logic [2:0]  te[6];
    int lat;
    ta = '{32'h8000_0000, 32'h8000_0000, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h0000_0001, 32'h0000_0001};
    tb = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h0000_0000, 32'h0000_0000};
    ts = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    te = '{3'b100, 3'b001, 3'b010, 3'b010, 3'b100, 3'b100};
    ready_i = 1'b1;
    for (int v = 0; v < 6; v++) begin
      tick();
      a_i = ta[v]; b_i = tb[v]; signed_i = ts[v]; valid_i = 1'b1;
      lat = 0;
      for (int n = 1; n <= 10; n++) begin
        tick();
        valid_i = 1'b0;
        #1;
        if (valid_o) begin lat = n; break; end
      end
      n_cmp++;
      if (lat != 4) begin n_bad++; $display("FAIL dir_latency[%0d]: got %0d expected 4", v, lat); end
      n_cmp++;
      if ({greater_o, equal_o, lesser_o} !== te[v]) begin
        n_bad++; $display("FAIL dir_flags[%0d]: got %b expected %b", v, {greater_o, equal_o, lesser_o}, te[v]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int out_idx = 0;
    exp_q.delete();
    ready_i = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (c < 8) begin
        valid_i = 1'b1; a_i = $urandom; b_i = pick_b(a_i); signed_i = 1'($urandom_range(0, 1));
      end else begin
        valid_i = 1'b0;
      end
      #1;
      if (valid_i && ready_o) exp_q.push_back(model32(a_i, b_i, signed_i));
      if (valid_o) begin
        n_cmp++;
        if (c != out_idx + 4) begin
          n_bad++; $display("FAIL b2b_cycle[%0d]: got cycle %0d expected %0d", out_idx, c, out_idx + 4);
        end
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++; $display("FAIL b2b_extra: got result %b expected none", {greater_o, equal_o, lesser_o});
        end else begin
          if ({greater_o, equal_o, lesser_o} !== exp_q[0]) begin
            n_bad++; $display("FAIL b2b_flags[%0d]: got %b expected %b", out_idx, {greater_o, equal_o, lesser_o}, exp_q[0]);
          end
          void'(exp_q.pop_front());
        end
        out_idx++;
      end
    end
    n_cmp++;
    if (out_idx != 8) begin n_bad++; $display("FAIL b2b_count: got %0d expected 8", out_idx); end
  endtask

  task automatic test_stall();
    int acc = 0;
    int retired = 0;
    logic [2:0] snap;
    exp_q.delete();
    ready_i = 1'b0;
    for (int n = 0; n < 10; n++) begin
      tick();
      valid_i = 1'b1; a_i = $urandom; b_i = pick_b(a_i); signed_i = 1'($urandom_range(0, 1));
      #1;
      if (ready_o) begin exp_q.push_back(model32(a_i, b_i, signed_i)); acc++; end
      else break;
    end
    n_cmp++;
    if (acc != 4) begin n_bad++; $display("FAIL stall_fill: got %0d accepted expected 4", acc); end
    snap = {greater_o, equal_o, lesser_o};
    n_cmp++;
    if (valid_o !== 1'b1 || exp_q.size() == 0 || snap !== exp_q[0]) begin
      n_bad++; $display("FAIL stall_head: got valid=%b flags=%b expected valid=1 flags=%b",
                        valid_o, snap, (exp_q.size() != 0) ? exp_q[0] : 3'bxxx);
    end
    for (int n = 0; n < 3; n++) begin
      tick();
      a_i = $urandom; b_i = $urandom;
      #1;
      n_cmp++;
      if (ready_o !== 1'b0 || valid_o !== 1'b1 || {greater_o, equal_o, lesser_o} !== snap) begin
        n_bad++; $display("FAIL stall_hold[%0d]: got ready=%b valid=%b flags=%b expected 0 1 %b",
                          n, ready_o, valid_o, {greater_o, equal_o, lesser_o}, snap);
      end
    end
    for (int n = 0; n < 12; n++) begin
      tick();
      if (n == 0) begin valid_i = 1'b0; ready_i = 1'b1; end
      #1;
      if (valid_o && ready_i) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++; $display("FAIL stall_extra: got result %b expected none", {greater_o, equal_o, lesser_o});
        end else begin
          if ({greater_o, equal_o, lesser_o} !== exp_q[0]) begin
            n_bad++; $display("FAIL stall_drain[%0d]: got %b expected %b", retired, {greater_o, equal_o, lesser_o}, exp_q[0]);
          end
          void'(exp_q.pop_front());
        end
        retired++;
      end
    end
    n_cmp++;
    if (retired != 4) begin n_bad++; $display("FAIL stall_count: got %0d expected 4", retired); end
  endtask

  task automatic test_reset_flush();
    ready_i = 1'b1;
    for (int n = 0; n < 3; n++) begin
      tick();
      valid_i = 1'b1; a_i = $urandom; b_i = pick_b(a_i); signed_i = 1'($urandom_range(0, 1));
    end
    tick();
    valid_i = 1'b0;
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    #1;
    n_cmp++;
    if (valid_o !== 1'b0 || {greater_o, equal_o, lesser_o} !== 3'b000) begin
      n_bad++; $display("FAIL flush_clear: got valid=%b flags=%b expected 0 000", valid_o, {greater_o, equal_o, lesser_o});
    end
    n_cmp++;
    if (ready_o !== 1'b1) begin n_bad++; $display("FAIL flush_ready: got %b expected 1", ready_o); end
    for (int n = 0; n < 10; n++) begin
      tick();
      #1;
      n_cmp++;
      if (valid_o !== 1'b0) begin n_bad++; $display("FAIL flush_stale[%0d]: got valid=%b expected 0", n, valid_o); end
    end
    exp_q.delete();
  endtask

  task automatic test_random();
    int retired = 0;
    exp_q.delete();
    for (int n = 0; n < 400; n++) begin
      tick();
      valid_i  = ($urandom_range(0, 3) != 0);
      a_i      = $urandom;
      b_i      = pick_b(a_i);
      signed_i = 1'($urandom_range(0, 1));
      ready_i  = (n >= 380) ? 1'b1 : ($urandom_range(0, 3) != 0);
      if (n >= 370) valid_i = 1'b0;
      #1;
      n_cmp++;
      if (ready_o !== (~valid_o | ready_i)) begin
        n_bad++; $display("FAIL rand_ready[%0d]: got %b expected %b", n, ready_o, ~valid_o | ready_i);
      end
      if (!valid_o) begin
        n_cmp++;
        if ({greater_o, equal_o, lesser_o} !== 3'b000) begin
          n_bad++; $display("FAIL rand_idle_flags[%0d]: got %b expected 000", n, {greater_o, equal_o, lesser_o});
        end
      end else if (ready_i) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++; $display("FAIL rand_extra[%0d]: got result %b expected none", n, {greater_o, equal_o, lesser_o});
        end else begin
          if ({greater_o, equal_o, lesser_o} !== exp_q[0]) begin
            n_bad++; $display("FAIL rand_flags[%0d]: got %b expected %b", retired, {greater_o, equal_o, lesser_o}, exp_q[0]);
          end
          void'(exp_q.pop_front());
        end
        retired++;
      end
      if (valid_i && ready_o) exp_q.push_back(model32(a_i, b_i, signed_i));
    end
    n_cmp++;
    if (exp_q.size() != 0) begin n_bad++; $display("FAIL rand_lost: got %0d pending expected 0", exp_q.size()); end
  endtask

  task automatic test_wide();
    logic [63:0] wa, wb;
    logic        ws;
    logic [2:0]  we;
    int lat;
    for (int v = 0; v < 11; v++) begin
      case (v)
        0:       begin wa = '1; wb = '0; ws = 1'b1; we = 3'b001; end
        1:       begin wa = '1; wb = '0; ws = 1'b0; we = 3'b100; end
        2:       begin wa = 64'h8000_0000_0000_0000; wb = 64'h7FFF_FFFF_FFFF_FFFF; ws = 1'b1; we = 3'b001; end
        default: begin
          wa = {$urandom, $urandom};
          wb = ($urandom_range(0, 2) == 0) ? wa : (wa ^ (64'h1 << $urandom_range(0, 63)));
          ws = 1'($urandom_range(0, 1));
          we = model64(wa, wb, ws);
        end
      endcase
      tick();
      w_a_i = wa; w_b_i = wb; w_signed_i = ws; w_valid_i = 1'b1;
      lat = 0;
      for (int n = 1; n <= 10; n++) begin
        tick();
        w_valid_i = 1'b0;
        #1;
        if (w_valid_o) begin lat = n; break; end
      end
      n_cmp++;
      if (lat != 4) begin n_bad++; $display("FAIL wide_latency[%0d]: got %0d expected 4", v, lat); end
      n_cmp++;
      if ({w_greater_o, w_equal_o, w_lesser_o} !== we) begin
        n_bad++; $display("FAIL wide_flags[%0d]: got %b expected %b", v, {w_greater_o, w_equal_o, w_lesser_o}, we);
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_stall();
    test_reset_flush();
    test_random();
    test_wide();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
